// File: rtl/fp_minmax_select_if.sv
// rtl/fp_minmax_select_if.sv - operand/result bundle for the FP min/max selector
//
// Purpose: groups the operand-side inputs, the comparator flag and the
// ordered-pair results of fp_minmax_select into one interface.
//   master : upstream driver (drives operands, tag and less_in; observes results)
//   slave  : the selector itself (consumes operands, produces results)
// Signals:
//   in_valid/in_a/in_b/in_tag : operand pair, same cycle it enters the comparator
//   less_in                   : comparator flag (A < B), valid CMP_LAT cycles later
//   out_valid/out_min/out_max/out_tag/out_a_lt_b/out_nan : ordered result
//   pair_count                : saturating count of emitted pairs
interface fp_minmax_select_if #(
    parameter int WIDTH = 65,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic [WIDTH:0]   in_a;
    logic [WIDTH:0]   in_b;
    logic [TAG_W-1:0] in_tag;
    logic             less_in;
    logic             out_valid;
    logic [WIDTH:0]   out_min;
    logic [WIDTH:0]   out_max;
    logic [TAG_W-1:0] out_tag;
    logic             out_a_lt_b;
    logic             out_nan;
    logic [15:0]      pair_count;

    modport master (
        output in_valid, in_a, in_b, in_tag, less_in,
        input  out_valid, out_min, out_max, out_tag, out_a_lt_b, out_nan, pair_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, less_in,
        output out_valid, out_min, out_max, out_tag, out_a_lt_b, out_nan, pair_count
    );
endinterface

// File: rtl/fp_minmax_select.sv
// rtl/fp_minmax_select.sv - pipelined min/max selector driven by an FP less-than flag
//
// Purpose: delays a FloPoCo operand pair and its tag by CMP_LAT stages so it
// lines up with the comparator's registered less flag, then registers the
// ordered pair (min, max). Latency CMP_LAT+1, one pair per cycle, no stall.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fp_minmax_select_if.slave (operands, less_in, results, pair_count)
// Parameters: WIDTH (operand MSB index), CMP_LAT (1..16), TAG_W.
// Configuration macro: FP_MINMAX_NAN_EN - when defined, an operand with
// exn==2'b11 overrides less_in and is reported as both min and max; when
// undefined, out_nan is constant 0 and no exn decode exists.
module fp_minmax_select #(
    parameter int WIDTH   = 65,
    parameter int CMP_LAT = 3,
    parameter int TAG_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    fp_minmax_select_if.slave bus
);
    localparam int AL = CMP_LAT - 1;  // stage aligned with less_in

    // Delay line: only the valid bits need reset, payload just follows.
    logic [CMP_LAT-1:0] vld_q;
    logic [WIDTH:0]     a_q   [CMP_LAT];
    logic [WIDTH:0]     b_q   [CMP_LAT];
    logic [TAG_W-1:0]   tag_q [CMP_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= bus.in_valid;
            for (int k = 1; k < CMP_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        a_q[0]   <= bus.in_a;
        b_q[0]   <= bus.in_b;
        tag_q[0] <= bus.in_tag;
        for (int k = 1; k < CMP_LAT; k++) begin
            a_q[k]   <= a_q[k-1];
            b_q[k]   <= b_q[k-1];
            tag_q[k] <= tag_q[k-1];
        end
    end

    // Output register and its next state.
    logic             valid_q, valid_d;
    logic [WIDTH:0]   min_q, min_d;
    logic [WIDTH:0]   max_q, max_d;
    logic [TAG_W-1:0] otag_q, otag_d;
    logic             lt_q, lt_d;
    logic [15:0]      cnt_q, cnt_d;
`ifdef FP_MINMAX_NAN_EN
    logic             nan_q, nan_d;
    logic             a_nan, b_nan;

    assign a_nan = (a_q[AL][WIDTH:WIDTH-1] == 2'b11);
    assign b_nan = (b_q[AL][WIDTH:WIDTH-1] == 2'b11);
`endif

    always_comb begin
        valid_d = 1'b0;
        min_d   = min_q;
        max_d   = max_q;
        otag_d  = otag_q;
        lt_d    = lt_q;
`ifdef FP_MINMAX_NAN_EN
        nan_d   = nan_q;
`endif
        if (vld_q[AL]) begin
            valid_d = 1'b1;
            otag_d  = tag_q[AL];
            lt_d    = bus.less_in;
            // Ties (equal values, +0/-0) fall into the else branch, so A is max.
            if (bus.less_in) begin
                min_d = a_q[AL];
                max_d = b_q[AL];
            end else begin
                min_d = b_q[AL];
                max_d = a_q[AL];
            end
`ifdef FP_MINMAX_NAN_EN
            // NaN propagates to both outputs; A wins when both are NaN.
            if (a_nan) begin
                min_d = a_q[AL];
                max_d = a_q[AL];
            end else if (b_nan) begin
                min_d = b_q[AL];
                max_d = b_q[AL];
            end
            nan_d = a_nan | b_nan;
`endif
        end
        // Count in the same cycle the pulse is presented, sticking at all-ones.
        cnt_d = cnt_q;
        if (valid_d && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            min_q   <= '0;
            max_q   <= '0;
            otag_q  <= '0;
            lt_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            min_q   <= min_d;
            max_q   <= max_d;
            otag_q  <= otag_d;
            lt_q    <= lt_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FP_MINMAX_NAN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nan_q <= 1'b0;
        end else begin
            nan_q <= nan_d;
        end
    end
    assign bus.out_nan = nan_q;
`else
    assign bus.out_nan = 1'b0;
`endif

    assign bus.out_valid  = valid_q;
    assign bus.out_min    = min_q;
    assign bus.out_max    = max_q;
    assign bus.out_tag    = otag_q;
    assign bus.out_a_lt_b = lt_q;
    assign bus.pair_count = cnt_q;
endmodule

// File: tb/tb_fp_minmax_select.sv
// tb/tb_fp_minmax_select.sv - directed self-checking bench for fp_minmax_select
module tb_fp_minmax_select;
    localparam int WIDTH   = 65;
    localparam int CMP_LAT = 3;
    localparam int TAG_W   = 8;

    localparam logic [65:0] ONE  = 66'h1_3FF0000000000000;
    localparam logic [65:0] TWO  = 66'h1_4000000000000000;
    localparam logic [65:0] PZ   = 66'h0_0000000000000000;
    localparam logic [65:0] NZ   = 66'h0_8000000000000000;
    localparam logic [65:0] QNAN = 66'h3_0000000000000000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_minmax_select_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    fp_minmax_select #(.WIDTH(WIDTH), .CMP_LAT(CMP_LAT), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Comparator stand-in: the hand-chosen less flag for each pair is delayed
    // CMP_LAT cycles, exactly like the real comparator's registered output.
    logic               lreq;
    logic [CMP_LAT-1:0] lpipe = '0;
    always @(posedge clk) lpipe <= {lpipe[CMP_LAT-2:0], lreq};
    assign bus.less_in = lpipe[CMP_LAT-1];

    int checks = 0;
    int errors = 0;

    logic          obs_v [28];
    logic [7:0]    obs_t [28];
    int            vcount;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive after the rising edge, return at the falling edge.
    task automatic cyc(input logic v, input logic [65:0] a, input logic [65:0] b,
                       input logic [7:0] tag, input logic lq);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        lreq         = lq;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, PZ, PZ, 8'h00, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {65'd0, bus.out_valid}, 66'd0);
        check({tag, "_min"}, bus.out_min, 66'd0);
        check({tag, "_max"}, bus.out_max, 66'd0);
        check({tag, "_tag"}, {58'd0, bus.out_tag}, 66'd0);
        check({tag, "_lt"}, {65'd0, bus.out_a_lt_b}, 66'd0);
        check({tag, "_nan"}, {65'd0, bus.out_nan}, 66'd0);
        check({tag, "_cnt"}, {50'd0, bus.pair_count}, 66'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_tag   = '0;
        lreq         = 1'b0;
        #12;
        check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic order: result must not appear early, then appears on the 4th cycle.
        cyc(1'b1, ONE, TWO, 8'd1, 1'b1);
        idle(3);
        check("basic_early", {65'd0, bus.out_valid}, 66'd0);
        idle(1);
        check("basic_valid", {65'd0, bus.out_valid}, 66'd1);
        check("basic_min", bus.out_min, ONE);
        check("basic_max", bus.out_max, TWO);
        check("basic_lt", {65'd0, bus.out_a_lt_b}, 66'd1);
        check("basic_tag", {58'd0, bus.out_tag}, 66'd1);
        check("basic_cnt", {50'd0, bus.pair_count}, 66'd1);
        idle(1);
        check("hold_valid", {65'd0, bus.out_valid}, 66'd0);
        check("hold_min", bus.out_min, ONE);
        check("hold_tag", {58'd0, bus.out_tag}, 66'd1);
        check("hold_cnt", {50'd0, bus.pair_count}, 66'd1);

        // Swap.
        cyc(1'b1, TWO, ONE, 8'd2, 1'b0);
        idle(4);
        check("swap_valid", {65'd0, bus.out_valid}, 66'd1);
        check("swap_min", bus.out_min, ONE);
        check("swap_max", bus.out_max, TWO);
        check("swap_lt", {65'd0, bus.out_a_lt_b}, 66'd0);
        check("swap_cnt", {50'd0, bus.pair_count}, 66'd2);

        // Tie +0 vs -0: A reported as max.
        cyc(1'b1, PZ, NZ, 8'd3, 1'b0);
        idle(4);
        check("tie_min", bus.out_min, NZ);
        check("tie_max", bus.out_max, PZ);
        check("tie_tag", {58'd0, bus.out_tag}, 66'd3);

        // NaN operand A.
        cyc(1'b1, QNAN, ONE, 8'd4, 1'b0);
        idle(4);
`ifdef FP_MINMAX_NAN_EN
        check("nan_min", bus.out_min, QNAN);
        check("nan_max", bus.out_max, QNAN);
        check("nan_flag", {65'd0, bus.out_nan}, 66'd1);
`else
        check("nan_min", bus.out_min, ONE);
        check("nan_max", bus.out_max, QNAN);
        check("nan_flag", {65'd0, bus.out_nan}, 66'd0);
`endif
        check("nan_lt", {65'd0, bus.out_a_lt_b}, 66'd0);
        check("nan_cnt", {50'd0, bus.pair_count}, 66'd4);

        // Streaming: tags 0..19, 3 idle, tag 20; observation i shows pair i-4.
        for (int i = 0; i < 28; i++) begin
            if (i < 20) cyc(1'b1, ONE, TWO, 8'(i), 1'b1);
            else if (i == 23) cyc(1'b1, ONE, TWO, 8'd20, 1'b1);
            else cyc(1'b0, PZ, PZ, 8'h00, 1'b0);
            obs_v[i] = bus.out_valid;
            obs_t[i] = bus.out_tag;
        end
        for (int i = 0; i < 28; i++) begin
            check($sformatf("stream_v%0d", i), {65'd0, obs_v[i]},
                  ((i >= 4 && i < 24) || i == 27) ? 66'd1 : 66'd0);
            if (i >= 4 && i < 24) check($sformatf("stream_t%0d", i), {58'd0, obs_t[i]}, 66'(i - 4));
        end
        check("stream_last_tag", {58'd0, obs_t[27]}, 66'd20);
        check("stream_cnt", {50'd0, bus.pair_count}, 66'd25);

        // Reset while three pairs are in flight.
        for (int k = 0; k < 3; k++) cyc(1'b1, TWO, ONE, 8'(30 + k), 1'b0);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check_zero("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (bus.out_valid === 1'b1) vcount++;
        end
        check("midrst_dropped", 66'(vcount), 66'd0);
        cyc(1'b1, ONE, TWO, 8'd40, 1'b1);
        idle(4);
        check("postrst_valid", {65'd0, bus.out_valid}, 66'd1);
        check("postrst_tag", {58'd0, bus.out_tag}, 66'd40);
        check("postrst_cnt", {50'd0, bus.pair_count}, 66'd1);

        // Saturation: count starts at 1; at call i (i>=3) count is i-2 until it sticks.
        vcount = 0;
        for (int i = 0; i < 65544; i++) begin
            if (i < 65540) cyc(1'b1, ONE, TWO, 8'(i), 1'b1);
            else cyc(1'b0, PZ, PZ, 8'h00, 1'b0);
            if (bus.out_valid === 1'b1) vcount++;
            if (i == 65536) check("sat_fffe", {50'd0, bus.pair_count}, 66'h0FFFE);
            if (i == 65537) check("sat_ffff", {50'd0, bus.pair_count}, 66'h0FFFF);
            if (i == 65538) check("sat_stick", {50'd0, bus.pair_count}, 66'h0FFFF);
        end
        check("sat_pulses", 66'(vcount), 66'd65540);
        check("sat_final", {50'd0, bus.pair_count}, 66'h0FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
